// File: rtl/mips_runctl.sv
// Run-control block for a MIPS core: holds the core in reset after power-up,
// then gates its clock enable for free-run, N-cycle run and single step,
// stopping on host HALT, address breakpoints or count expiry.
module mips_runctl #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned BREAK_N      = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic [1:0]                i_cmd_op,
  input  logic [CNT_W-1:0]          i_cmd_arg,
  input  logic [ADDR_W-1:0]         i_pc,
  input  logic [BREAK_N*ADDR_W-1:0] i_bp_addr,
  input  logic [BREAK_N-1:0]        i_bp_en,
  output logic                      o_core_reset,
  output logic                      o_core_en,
  output logic [2:0]                o_state,
  output logic [CNT_W-1:0]          o_cycles,
  output logic                      o_halted,
  output logic [2:0]                o_halt_cause
);

  typedef enum logic [2:0] {
    StReset = 3'd0,
    StIdle  = 3'd1,
    StRun   = 3'd2,
    StCount = 3'd3,
    StStep  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CauseNone  = 3'd0,
    CauseHost  = 3'd1,
    CauseCount = 3'd2,
    CauseBp    = 3'd3,
    CauseStep  = 3'd4
  } cause_e;

  localparam logic [1:0] OpRun  = 2'd0;
  localparam logic [1:0] OpStep = 2'd1;
  localparam logic [1:0] OpRunN = 2'd2;
  localparam logic [1:0] OpHalt = 2'd3;

  // Reset counter only needs to reach RESET_CYCLES-1.
  localparam int unsigned RcW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RcW-1:0] RcLast = RcW'(RESET_CYCLES - 1);

  state_e           r_state;
  cause_e           r_halt_cause;
  logic [RcW-1:0]   r_rst_cnt;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_cycles;
  logic             r_skip;
  logic             r_halted;

  logic w_active;
  logic w_accept;
  logic w_halt_cmd;
  logic w_bp_match;
  logic w_bp_hit;
  logic w_core_en;

  // Any enabled comparator whose address equals the current fetch PC.
  always_comb begin
    w_bp_match = 1'b0;
    for (int i = 0; i < BREAK_N; i++) begin
      if (i_bp_en[i] && (i_pc == i_bp_addr[i*ADDR_W +: ADDR_W])) begin
        w_bp_match = 1'b1;
      end
    end
  end

  // Command handshake, stop conditions and the combinational core enable.
  always_comb begin
    w_active   = (r_state == StRun) || (r_state == StCount) || (r_state == StStep);
    w_accept   = i_cmd_valid && (r_state != StReset);
    w_halt_cmd = w_accept && (i_cmd_op == OpHalt);
    // First cycle after entry ignores breakpoints so a resume from a BP address advances.
    w_bp_hit   = w_active && w_bp_match && !r_skip;
    w_core_en  = w_active && !w_halt_cmd && !w_bp_hit;
  end

  // Run-control state machine, halt reporting and enabled-cycle counter.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state      <= StReset;
      r_halt_cause <= CauseNone;
      r_rst_cnt    <= '0;
      r_remaining  <= '0;
      r_cycles     <= '0;
      r_skip       <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_halted <= 1'b0;
      if (w_core_en) begin
        r_cycles <= r_cycles + CNT_W'(1);
      end
      unique case (r_state)
        StReset: begin
          if (r_rst_cnt == RcLast) begin
            r_state   <= StIdle;
            r_rst_cnt <= '0;
          end else begin
            r_rst_cnt <= r_rst_cnt + RcW'(1);
          end
        end
        StIdle: begin
          // HALT while idle is accepted but changes nothing, not even the cause.
          if (w_accept && (i_cmd_op != OpHalt)) begin
            r_halt_cause <= CauseNone;
            r_skip       <= 1'b1;
            unique case (i_cmd_op)
              OpRun:  r_state <= StRun;
              OpStep: r_state <= StStep;
              OpRunN: begin
                if (i_cmd_arg == '0) begin
                  // Zero-length run completes immediately without enabling the core.
                  r_halted     <= 1'b1;
                  r_halt_cause <= CauseCount;
                  r_skip       <= 1'b0;
                end else begin
                  r_state     <= StCount;
                  r_remaining <= i_cmd_arg;
                end
              end
              default: ;
            endcase
          end
        end
        StRun, StCount, StStep: begin
          r_skip <= 1'b0;
          // Priority: host HALT, then breakpoint, then step/count completion.
          if (w_halt_cmd) begin
            r_state      <= StIdle;
            r_halted     <= 1'b1;
            r_halt_cause <= CauseHost;
            r_remaining  <= '0;
          end else if (w_bp_hit) begin
            r_state      <= StIdle;
            r_halted     <= 1'b1;
            r_halt_cause <= CauseBp;
            r_remaining  <= '0;
          end else if (r_state == StStep) begin
            r_state      <= StIdle;
            r_halted     <= 1'b1;
            r_halt_cause <= CauseStep;
          end else if (r_state == StCount) begin
            if (r_remaining == CNT_W'(1)) begin
              r_state      <= StIdle;
              r_halted     <= 1'b1;
              r_halt_cause <= CauseCount;
              r_remaining  <= '0;
            end else begin
              r_remaining <= r_remaining - CNT_W'(1);
            end
          end
        end
        default: r_state <= StReset;
      endcase
    end
  end

  // Outputs are decodes of registered state except the enable, which must react in-cycle.
  always_comb begin
    o_cmd_ready  = (r_state != StReset);
    o_core_reset = (r_state == StReset);
    o_core_en    = w_core_en;
    o_state      = r_state;
    o_cycles     = r_cycles;
    o_halted     = r_halted;
    o_halt_cause = r_halt_cause;
  end

endmodule

// File: doc/mips_runctl.md
MIPS_RUNCTL -- requirements
Module: Mips_runctl

Interface
- REQ-001 Parameter RESET_CYCLES, default 2, SHALL set cycles core_reset is held after reset_n release; legal range >= 1.
- REQ-002 Parameter CNT_W, default 32, SHALL set width of cycle counter and run-count argument.
- REQ-003 Parameter ADDR_W, default 32, SHALL set PC and breakpoint address width.
- REQ-004 Parameter BREAK_N, default 2, SHALL set number of breakpoint comparators.
- REQ-005 clock  in  1  SHALL be the single clock; all state changes on its rising edge.
- REQ-006 reset_n  in  1  SHALL be a synchronous, active-low reset.
- REQ-007 cmd_valid  in  1  command present; cmd_ready  out  1  command accepted when both are high.
- REQ-008 cmd_op  in  2  SHALL encode 0=RUN, 1=STEP, 2=RUN_N, 3=HALT; cmd_arg  in  CNT_W  SHALL carry the cycle count for RUN_N.
- REQ-009 pc  in  ADDR_W  SHALL carry the core's current fetch address.
- REQ-010 bp_addr  in  BREAK_N*ADDR_W  packed breakpoint addresses, comparator i at bits [i*ADDR_W +: ADDR_W]; bp_en  in  BREAK_N  per-comparator enable.
- REQ-011 core_reset  out  1  active-high core reset; core_en  out  1  core clock enable.
- REQ-012 state  out  3  SHALL encode 0=RESET, 1=IDLE, 2=RUN, 3=COUNT, 4=STEP.
- REQ-013 cycles  out  CNT_W  count of enabled cycles; halted  out  1  single-cycle halt pulse; halt_cause  out  3  SHALL encode 0=NONE, 1=HOST, 2=COUNT, 3=BP, 4=STEP.

Function
- REQ-014 RESET: core_reset=1, core_en=0, cmd_ready=0; SHALL move to IDLE after RESET_CYCLES cycles with reset_n high, core_reset=0 from that IDLE cycle.
- REQ-015 IDLE: cmd_ready=1, core_en=0; accepted RUN->RUN, STEP->STEP, RUN_N(N>0)->COUNT with remaining=N; RUN_N(0) SHALL stay IDLE with halted pulse, cause COUNT; HALT SHALL be accepted with no effect.
- REQ-016 Any accepted command other than a HALT in IDLE SHALL clear halt_cause to NONE.
- REQ-017 Command accepted at cycle t SHALL give first core_en=1 at cycle t+1.
- REQ-018 RUN/COUNT/STEP: cmd_ready=1; only HALT acted on, all other ops accepted and discarded.
- REQ-019 core_en SHALL be combinational: 1 in RUN/COUNT/STEP unless a HALT is accepted or an unskipped breakpoint matches that cycle.
- REQ-020 Breakpoint match = any i with bp_en[i]=1 and pc == bp_addr[i]; SHALL be ignored on the first cycle after entry to RUN/COUNT/STEP (skip flag), so resuming from a breakpoint PC advances.
- REQ-021 Match in RUN/COUNT SHALL force core_en=0 that cycle and go to IDLE, cause BP.
- REQ-022 COUNT: remaining decrements per enabled cycle; enabled cycle with remaining==1 SHALL go to IDLE, cause COUNT (exactly N enabled cycles absent interruption).
- REQ-023 STEP: exactly one core_en=1 cycle, then IDLE, cause STEP.
- REQ-024 Same-cycle priority SHALL be HALT (HOST) > breakpoint (BP) > count expiry (COUNT).
- REQ-025 halted SHALL pulse for exactly the first IDLE cycle after leaving RUN/COUNT/STEP; halt_cause SHALL hold until next non-HALT accepted command.
- REQ-026 cycles SHALL increment by 1 on each core_en=1 cycle, wrap modulo 2^CNT_W, and clear only on reset.

Reset
- REQ-027 reset_n=0 at an edge SHALL set state=RESET, core_reset=1, core_en=0, cmd_ready=0, cycles=0, remaining=0, halted=0, halt_cause=NONE, reset counter=0, from any state including mid-COUNT.

Verification
- REQ-028 reset_n low 3 cycles then high, RESET_CYCLES=2 -> core_reset=1 two further cycles, then state=IDLE, core_reset=0, cmd_ready=1, cycles=0.
- REQ-029 RUN_N arg=5 from IDLE -> core_en=1 exactly 5 consecutive cycles, cycles=5, one halted pulse, halt_cause=2.
- REQ-030 bp_addr[0]=0x10, bp_en=01, RUN, pc 0,4,8,0xC,0x10 -> core_en=1 for pc 0..0xC, 0 at 0x10, halt_cause=3; then STEP -> one enabled cycle at pc=0x10, halt_cause=4.
- REQ-031 HALT accepted in RUN on the same cycle as a breakpoint match -> core_en=0, halt_cause=1.
- REQ-032 CNT_W=4, RUN_N arg=15 then RUN_N arg=2 -> cycles=1 (wrap).
- REQ-033 reset_n low during COUNT with remaining=7 -> next cycle state=RESET, core_en=0, cycles=0, halted=0.
